// File: rtl/rburst_gen.sv
// Read burst generator: splits a beat-count request into credit-gated bursts that never cross 4 KB.
// Latency: first descriptor the cycle after acceptance; rd_done one cycle after the final beat.
// Backpressure: descriptor held stable until rburst_ready; issue stalls while credits < burst beats.
module rburst_gen #(
    parameter int ADDR_W             = 32,
    parameter int BEAT_BYTES_LOG2    = 3,
    parameter int RBURST_LEN         = 4,
    parameter int RBURST_COUNTER_LEN = 16,
    parameter int MAX_BURST_LEN      = 16,
    parameter int BUF_DEPTH          = 64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rd_req_valid,
    output logic                          rd_req_ready,
    input  logic [ADDR_W-1:0]             rd_req_addr,
    input  logic [RBURST_COUNTER_LEN-1:0] rd_req_num_beats,
    output logic                          rburst_valid,
    input  logic                          rburst_ready,
    output logic [ADDR_W-1:0]             rburst_addr,
    output logic [RBURST_LEN-1:0]         rburst_len,
    input  logic                          rbeat_valid,
    input  logic                          rdata_consumed,
    output logic                          rd_busy,
    output logic                          rd_done
);
    localparam int CNT_W  = RBURST_COUNTER_LEN;
    localparam int CRED_W = $clog2(BUF_DEPTH) + 1;
    localparam int CALC_W = ((CNT_W > 13) ? CNT_W : 13) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  rcvd;
    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] credits_nx;
    logic              done_q;
    logic              done_nx;
    logic [12:0]       page_left;
    logic [12:0]       page_beats;
    logic [CALC_W-1:0] beats;
    logic              credit_ok;
    logic              accept;
    logic              hs;
    logic              busy_w;
    logic              last_beat;

    assign rd_done = done_q;

    // Beats left before the next 4 KB page boundary.
    assign page_left  = 13'd4096 - {1'b0, cur_addr[11:0]};
    assign page_beats = page_left >> BEAT_BYTES_LOG2;

    always_comb begin
        beats = CALC_W'(remaining);
        if (beats > CALC_W'(MAX_BURST_LEN)) beats = CALC_W'(MAX_BURST_LEN);
        if (beats > CALC_W'(page_beats))    beats = CALC_W'(page_beats);
    end

    assign credit_ok = (CALC_W'(credits) >= beats);
    // The rd_done cycle is spent in IDLE but must not take a new request.
    assign accept    = rd_req_valid && (state == IDLE) && !done_q;
    assign hs        = rburst_valid && rburst_ready;
    assign busy_w    = (state != IDLE);
    assign last_beat = busy_w && rbeat_valid && ((rcvd + CNT_W'(1)) == num_q);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        done_nx      = 1'b0;
        rd_req_ready = 1'b0;
        rd_busy      = 1'b0;
        rburst_valid = 1'b0;
        rburst_addr  = '0;
        rburst_len   = '0;
        case (state)
            IDLE: begin
                rd_req_ready = !done_q;
                if (accept) begin
                    if (rd_req_num_beats == '0) done_nx  = 1'b1;
                    else                        state_nx = ISSUE;
                end
            end
            ISSUE: begin
                rd_busy      = 1'b1;
                rburst_valid = credit_ok;
                rburst_addr  = cur_addr;
                rburst_len   = RBURST_LEN'(beats - CALC_W'(1));
                if (rburst_valid && rburst_ready && (CALC_W'(remaining) == beats))
                    state_nx = WAIT_DATA;
            end
            WAIT_DATA: begin
                rd_busy = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        // Completion wins over any state, including a still-issuing one.
        if (last_beat) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
        end
    end

    always_comb begin
        credits_nx = credits;
        if (hs) credits_nx = credits_nx - CRED_W'(beats);
        if (rdata_consumed && (credits != CRED_W'(BUF_DEPTH)))
            credits_nx = credits_nx + CRED_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_addr  <= '0;
            remaining <= '0;
            num_q     <= '0;
            rcvd      <= '0;
            credits   <= CRED_W'(BUF_DEPTH);
            done_q    <= 1'b0;
        end else begin
            credits <= credits_nx;
            done_q  <= done_nx;
            if (accept) begin
                cur_addr  <= rd_req_addr & ~ADDR_W'((1 << BEAT_BYTES_LOG2) - 1);
                remaining <= rd_req_num_beats;
                num_q     <= rd_req_num_beats;
                rcvd      <= '0;
            end else begin
                if (hs) begin
                    cur_addr  <= cur_addr + (ADDR_W'(beats) << BEAT_BYTES_LOG2);
                    remaining <= remaining - CNT_W'(beats);
                end
                if (busy_w && rbeat_valid) rcvd <= rcvd + CNT_W'(1);
            end
        end
    end
endmodule
